// File: rtl/keycode_mapper_if.sv
// keycode_mapper_if
// Byte stream from the NIOS II keyboard handler into the keycode mapper.
//   key_valid : source presents a keycode byte
//   key_data  : USB HID keycode byte
//   key_last  : final byte of a report (qualified by key_valid)
//   key_ready : sink accepts a byte this cycle
// Modports: master = byte source, slave = keycode_mapper.
interface keycode_mapper_if;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_last;
  logic       key_ready;

  modport master (output key_valid, output key_data, output key_last, input key_ready);
  modport slave  (input key_valid, input key_data, input key_last, output key_ready);
endinterface

// File: rtl/keycode_mapper.sv
// keycode_mapper
// Turns HID boot-protocol keyboard reports into NES controller button state.
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   key_if     : keycode byte stream (slave side)
//   buttons    : NES buttons, 1 = pressed, bit0..7 = A B Sel Start Up Down Left Right
//   update     : one-cycle pulse when buttons loads a committed report
//   stale      : one-cycle pulse when the timeout releases all buttons
//   report_err : one-cycle pulse when a report is discarded
//
// state   | meaning
// IDLE    | waiting for the first byte of a report
// COLLECT | accumulating further bytes of a good report
// COMMIT  | one cycle, loads buttons from the accumulator
// DROP    | swallowing the rest of a bad report until key_last
module keycode_mapper #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int MAX_SLOTS      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  keycode_mapper_if.slave        key_if,
  output logic [7:0]             buttons,
  output logic                   update,
  output logic                   stale,
  output logic                   report_err
);

  localparam int                SLOT_W   = $clog2(MAX_SLOTS + 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(MAX_SLOTS);
  localparam logic [31:0]       TMR_MAX  = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, DROP} state_t;

  state_t            state, state_nx;
  logic [7:0]        acc;
  logic [SLOT_W-1:0] slot_cnt;
  logic [31:0]       tmr;

  logic ready_c;
  logic accept;
  logic bad_byte;
  logic load_first;
  logic load_more;
  logic err_fire;

  function automatic logic [7:0] map_key(input logic [7:0] code);
    logic [7:0] m;
    case (code)
      8'h0E:   m = 8'h01;
      8'h0D:   m = 8'h02;
      8'h2C:   m = 8'h04;
      8'h28:   m = 8'h08;
      8'h1A:   m = 8'h10;
      8'h16:   m = 8'h20;
      8'h04:   m = 8'h40;
      8'h07:   m = 8'h80;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Opposing directions cancel so the game never sees an impossible d-pad.
  function automatic logic [7:0] filter_dirs(input logic [7:0] b);
    logic [7:0] f;
    f = b;
    if (b[4] && b[5]) f[5:4] = 2'b00;
    if (b[6] && b[7]) f[7:6] = 2'b00;
    return f;
  endfunction

  // Ready is gated by rst so the source sees no acceptance while in reset.
  assign key_if.key_ready = ready_c && !rst;
  assign accept           = key_if.key_valid && key_if.key_ready;

  always_comb begin
    state_nx   = state;
    ready_c    = 1'b1;
    load_first = 1'b0;
    load_more  = 1'b0;
    err_fire   = 1'b0;
    bad_byte   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_first = 1'b1;
          bad_byte   = (key_if.key_data == 8'h01);
          if (bad_byte)             begin err_fire = key_if.key_last; state_nx = key_if.key_last ? IDLE : DROP; end
          else if (key_if.key_last) state_nx = COMMIT;
          else                      state_nx = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          // ErrorRollOver or one byte too many both poison the report.
          bad_byte = (key_if.key_data == 8'h01) || (slot_cnt == SLOT_MAX);
          if (bad_byte) begin
            err_fire = key_if.key_last;
            state_nx = key_if.key_last ? IDLE : DROP;
          end else begin
            load_more = 1'b1;
            if (key_if.key_last) state_nx = COMMIT;
          end
        end
      end
      COMMIT: begin
        ready_c  = 1'b0;
        state_nx = IDLE;
      end
      DROP: begin
        if (accept && key_if.key_last) begin
          err_fire = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      slot_cnt   <= '0;
      tmr        <= '0;
      buttons    <= '0;
      update     <= 1'b0;
      stale      <= 1'b0;
      report_err <= 1'b0;
    end else begin
      update     <= 1'b0;
      stale      <= 1'b0;
      report_err <= err_fire;

      if (load_first) begin
        acc      <= map_key(key_if.key_data);
        slot_cnt <= SLOT_W'(1);
      end else if (load_more) begin
        acc      <= acc | map_key(key_if.key_data);
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      // Commit takes priority over a timeout landing on the same cycle.
      if (state == COMMIT) begin
        buttons <= filter_dirs(acc);
        update  <= 1'b1;
        tmr     <= '0;
      end else if (tmr < TMR_MAX) begin
        tmr <= tmr + 32'd1;
        if (tmr == TMR_MAX - 32'd1) begin
          buttons <= '0;
          stale   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keycode_mapper.sv
// tb_keycode_mapper
// Directed bench for keycode_mapper with a short timeout (16 cycles).
module tb_keycode_mapper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keycode_mapper_if kif();
  logic [7:0] buttons;
  logic       update, stale, report_err;

  keycode_mapper #(.TIMEOUT_CYCLES(16), .MAX_SLOTS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_if     (kif.slave),
    .buttons    (buttons),
    .update     (update),
    .stale      (stale),
    .report_err (report_err)
  );

  int checks = 0;
  int errors = 0;
  int stale_cnt = 0;
  int upd_cnt = 0;

  always @(posedge clk) begin
    if (!rst && stale)  stale_cnt++;
    if (!rst && update) upd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_data  = d;
    kif.key_last  = l;
    while (!kif.key_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!kif.key_ready) check("ready_wait", 32'(kif.key_ready), 1);
    @(posedge clk);
  endtask

  task automatic send_report(input logic [7:0] b [8], input int n);
    for (int i = 0; i < n; i++) send_byte(b[i], i == n - 1);
    @(negedge clk);
    kif.key_valid = 1'b0;
    kif.key_data  = 8'h00;
    kif.key_last  = 1'b0;
  endtask

  // Ends on the negedge of cycle N+2 (last accept in cycle N).
  task automatic commit_check(input string tag, input logic [7:0] b [8], input int n,
                              input logic [7:0] exp);
    send_report(b, n);
    check({tag, "_commit_ready"}, 32'(kif.key_ready), 0);
    check({tag, "_early_update"}, 32'(update), 0);
    @(negedge clk);
    check({tag, "_buttons"}, 32'(buttons), 32'(exp));
    check({tag, "_update"}, 32'(update), 1);
  endtask

  task automatic err_check(input string tag, input logic [7:0] b [8], input int n,
                           input logic [7:0] exp);
    send_report(b, n);
    check({tag, "_report_err"}, 32'(report_err), 1);
    check({tag, "_ready"}, 32'(kif.key_ready), 1);
    @(negedge clk);
    check({tag, "_err_pulse_end"}, 32'(report_err), 0);
    check({tag, "_buttons"}, 32'(buttons), 32'(exp));
    check({tag, "_no_update"}, 32'(update), 0);
  endtask

  logic [7:0] r [8];
  int s0, u0;

  initial begin
    rst = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_data  = 8'h00;
    kif.key_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(kif.key_ready), 0);
    check("rst_buttons", 32'(buttons), 0);
    check("rst_pulses", {29'd0, update, stale, report_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(kif.key_ready), 1);

    r = '{8'h04, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("left_a", r, 6, 8'h41);
    @(negedge clk);
    check("update_one_cycle", 32'(update), 0);

    r = '{8'h1A, 8'h16, 8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("up_down_start", r, 3, 8'h08);

    r = '{8'h04, 8'h07, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("left_right_a", r, 3, 8'h01);

    r = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("right", r, 1, 8'h80);
    r = '{8'h07, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    err_check("rollover_last", r, 2, 8'h80);

    r = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("right2", r, 1, 8'h80);
    r = '{8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h00};
    err_check("seven_bytes", r, 7, 8'h80);

    r = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("right3", r, 1, 8'h80);
    r = '{8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h04};
    err_check("overflow_drop", r, 8, 8'h80);

    r = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("right4", r, 1, 8'h80);
    r = '{8'h01, 8'h0E, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    err_check("rollover_drop", r, 3, 8'h80);

    // Timeout: commit lands at t0, release expected 16 cycles later.
    r = '{8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("a_for_timeout", r, 1, 8'h01);
    s0 = stale_cnt;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check("to_hold_buttons", 32'(buttons), 1);
        check("to_hold_stale", 32'(stale), 0);
      end
      if (i == 16) begin
        check("to_buttons", 32'(buttons), 0);
        check("to_stale", 32'(stale), 1);
      end
    end
    repeat (20) @(negedge clk);
    check("to_stale_once", stale_cnt - s0, 1);

    // Commit whose COMMIT cycle coincides with the timeout cycle.
    commit_check("a_for_race", r, 1, 8'h01);
    s0 = stale_cnt;
    repeat (13) @(negedge clk);
    r = '{8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("race_start", r, 1, 8'h08);
    check("race_no_stale_now", 32'(stale), 0);
    repeat (3) @(negedge clk);
    check("race_no_stale", stale_cnt - s0, 0);

    // Reset in the middle of a report.
    send_byte(8'h0E, 1'b0);
    send_byte(8'h0D, 1'b0);
    @(negedge clk);
    kif.key_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(kif.key_ready), 0);
    check("midrst_buttons", 32'(buttons), 0);
    @(negedge clk);
    check("midrst_ready_hold", 32'(kif.key_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(kif.key_ready), 1);
    r = '{8'h2C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    commit_check("select_after_rst", r, 1, 8'h04);

    // Data and last with valid low must do nothing.
    u0 = upd_cnt;
    kif.key_valid = 1'b0;
    kif.key_data  = 8'h0E;
    kif.key_last  = 1'b1;
    repeat (5) @(negedge clk);
    check("novalid_update", upd_cnt - u0, 1);
    check("novalid_buttons", 32'(buttons), 32'h04);
    check("novalid_ready", 32'(kif.key_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_mapper.md
KEYCODE_MAPPER -- requirements
Module: keycode_mapper

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000000, means cycles without a committed report before buttons are forced released (100 ms at 50 MHz).
REQ-002 Parameter MAX_SLOTS, default 6, means the maximum number of keycode bytes in one report (HID boot protocol).
REQ-003 Clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  is an asynchronous, active-high reset.
REQ-005 key_valid  input  1  means the NIOS II side presents a keycode byte.
REQ-006 key_data  input  8  is the USB HID keycode byte.
REQ-007 key_last  input  1  marks the final byte of a report; it is qualified by key_valid.
REQ-008 key_ready  output  1  means the block accepts a byte this cycle; a transfer occurs when key_valid and key_ready are both high.
REQ-009 buttons  output  8  is the NES button state feeding the controller parallel-load input; 1 = pressed; bit order A, B, Select, Start, Up, Down, Left, Right (bit0..bit7).
REQ-010 update  output  1  is a one-cycle pulse when buttons is loaded from a committed report.
REQ-011 stale  output  1  is a one-cycle pulse when a timeout clears buttons.
REQ-012 report_err  output  1  is a one-cycle pulse when a report is discarded.

Function
REQ-013 Keycode map: 0x0E->A, 0x0D->B, 0x2C->Select, 0x28->Start, 0x1A->Up, 0x16->Down, 0x04->Left, 0x07->Right; 0x00 and all other codes contribute nothing.
REQ-014 FSM states: IDLE, COLLECT, COMMIT, DROP.
REQ-015 IDLE: key_ready=1; an accepted byte clears the accumulator, ORs in its mapped bit, sets slot count=1, and moves to COMMIT if key_last is set, else to COLLECT.
REQ-016 COLLECT: key_ready=1; each accepted byte ORs into the accumulator and increments the slot count; key_last moves to COMMIT.
REQ-017 A byte of 0x01 (HID ErrorRollOver) in any slot marks the report bad; a bad report goes to DROP instead of COLLECT, or pulses report_err and returns to IDLE if key_last is set.
REQ-018 An accepted byte that would be slot MAX_SLOTS+1 marks overflow and is handled identically to REQ-017.
REQ-019 DROP: key_ready=1; bytes are consumed and ignored until key_last; then report_err pulses and the FSM returns to IDLE; buttons is unchanged.
REQ-020 COMMIT lasts exactly one cycle with key_ready=0.
REQ-021 In COMMIT, buttons loads the filtered accumulator, update pulses, and the timeout counter clears; the new buttons value is visible on the cycle after COMMIT.
REQ-022 Latency: last byte accepted in cycle N gives buttons and update valid in cycle N+2.
REQ-023 Filter: if Up and Down are both set, both are cleared; if Left and Right are both set, both are cleared; A, B, Select and Start pass unchanged.
REQ-024 The timeout counter is 32 bits, increments every cycle outside COMMIT, and saturates at TIMEOUT_CYCLES.
REQ-025 On the cycle the counter reaches TIMEOUT_CYCLES: buttons <= 0, stale pulses once, and no further stale pulses occur until a new commit clears the counter.
REQ-026 If timeout and COMMIT coincide, COMMIT wins: buttons takes the report value and stale does not pulse.
REQ-027 Reports never partially update buttons; buttons changes only in COMMIT or on timeout.
REQ-028 key_data and key_last are ignored whenever key_valid=0.

Reset
REQ-029 Reset asserted forces FSM=IDLE, buttons=0, accumulator=0, slot count=0, timeout counter=0, and update=stale=report_err=0.
REQ-030 While Reset is high, key_ready=0; key_ready becomes 1 in the first cycle after release.
REQ-031 Reset mid-report discards the partial report; the next accepted byte starts a new report.

Verification
REQ-032 Report {0x04, 0x0E, 0x00, 0x00, 0x00, 0x00(last)} -> buttons=0x41 and update=1 two cycles after the last accept.
REQ-033 Report {0x1A, 0x16, 0x28(last)} -> buttons=0x08 (Up and Down cancelled, Start kept).
REQ-034 Report {0x07, 0x01(last)} after buttons=0x80 -> report_err pulses and buttons remains 0x80; seven-byte report -> report_err pulses and buttons unchanged.
REQ-035 With TIMEOUT_CYCLES=16 and buttons=0x01 -> after 16 idle cycles buttons=0x00 and stale pulses exactly once.
REQ-036 Reset asserted after two bytes of a report, then report {0x2C(last)} -> buttons=0x04; key_ready low while Reset is high.
